// File: rtl/pow2_arb_pkg.sv
// rtl/pow2_arb_pkg.sv - shared sizing helpers and constants for the pow2 arbiter slice
package pow2_arb_pkg;

    localparam int unsigned DEFAULT_NUM_REQ = 4;
    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_MAX_OUT = 4;

    // Value latched into the sticky error flag on a result with no owner
    localparam logic ERR_PROTOCOL = 1'b1;

    function automatic int unsigned tag_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pow2_arb_tag_fifo.sv
// rtl/pow2_arb_tag_fifo.sv - register-based FIFO of requester tags for in-flight pow2 operations
module pow2_arb_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pow2_arbiter.sv
// rtl/pow2_arbiter.sv - shares one pow2 unit among requesters; POW2_ARBITER_FIXED_PRIO_EN selects fixed priority
module pow2_arbiter
    import pow2_arb_pkg::*;
#(
    parameter int unsigned num_req_p = DEFAULT_NUM_REQ,
    parameter int unsigned width_p   = DEFAULT_WIDTH,
    parameter int unsigned max_out_p = DEFAULT_MAX_OUT
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [num_req_p-1:0]         req_v_i,
    input  logic [num_req_p*width_p-1:0] req_exp_i,
    output logic [num_req_p-1:0]         req_ready_o,
    output logic [num_req_p-1:0]         resp_v_o,
    output logic [width_p-1:0]           resp_data_o,
    input  logic [num_req_p-1:0]         resp_yumi_i,
    output logic [width_p-1:0]           pow2_exp_o,
    output logic                         pow2_v_o,
    input  logic                         pow2_ready_i,
    input  logic [width_p-1:0]           pow2_data_i,
    input  logic                         pow2_v_i,
    output logic                         pow2_yumi_o,
    output logic                         error_o
);

    localparam int unsigned TW = tag_width(num_req_p);
    localparam int unsigned CW = $clog2(max_out_p + 1);

    logic [num_req_p-1:0] w_search;
    logic [num_req_p-1:0] w_grant;
    logic [num_req_p-1:0] w_resp_v;
    logic [TW-1:0]        w_offset;
    logic [TW-1:0]        w_winner;
    logic [TW-1:0]        w_tag;
    logic [CW-1:0]        w_count;
    logic                 w_found;
    logic                 w_can_issue;
    logic                 w_issue;
    logic                 w_ret_ok;
    logic                 w_yumi;
    logic                 w_full;
    logic                 w_empty;
    logic                 r_error;

`ifdef POW2_ARBITER_FIXED_PRIO_EN
    assign w_search = req_v_i;
    assign w_winner = w_offset;
`else
    localparam int unsigned TW1 = TW + 1;

    logic [TW-1:0]  r_rr_ptr;
    logic [TW1-1:0] w_cand;
    logic [TW1-1:0] w_sum;

    // w_search[k] is the request k positions after the pointer
    always_comb begin
        w_search = '0;
        w_cand   = '0;
        for (int k = 0; k < num_req_p; k++) begin
            w_cand = {1'b0, r_rr_ptr} + TW1'(k);
            if (w_cand >= TW1'(num_req_p)) begin
                w_cand = w_cand - TW1'(num_req_p);
            end
            w_search[k] = req_v_i[w_cand[TW-1:0]];
        end
    end

    always_comb begin
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
        if (w_sum >= TW1'(num_req_p)) begin
            w_sum = w_sum - TW1'(num_req_p);
        end
        w_winner = w_sum[TW-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= (w_winner == TW'(num_req_p - 1)) ? '0 : w_winner + 1'b1;
        end
    end
`endif

    always_comb begin
        w_offset = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (w_search[k]) begin
                w_offset = TW'(k);
            end
        end
    end

    assign w_found = |w_search;

    // Count-based limit ignores a same-cycle pop, so grant never depends on resp_yumi_i
    assign w_can_issue = reset_n_i & pow2_ready_i & (w_count < CW'(max_out_p));

    always_comb begin
        w_grant    = '0;
        pow2_exp_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            w_grant[i] = w_can_issue & w_found & (w_winner == TW'(i));
            if (w_grant[i]) begin
                pow2_exp_o = req_exp_i[i*width_p +: width_p];
            end
        end
    end

    assign req_ready_o = w_grant;
    assign pow2_v_o    = |w_grant;
    assign w_issue     = pow2_v_o & pow2_ready_i;

    assign w_ret_ok = pow2_v_i & ~w_empty;

    always_comb begin
        w_resp_v = '0;
        w_yumi   = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            w_resp_v[i] = w_ret_ok & (w_tag == TW'(i));
            w_yumi      = w_yumi | (w_resp_v[i] & resp_yumi_i[i]);
        end
    end

    assign resp_v_o    = w_resp_v;
    assign pow2_yumi_o = w_yumi;
    assign resp_data_o = w_ret_ok ? pow2_data_i : '0;

    pow2_arb_tag_fifo #(
        .DEPTH (max_out_p),
        .WIDTH (TW)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .i_push      (w_issue),
        .i_push_data (w_winner),
        .i_pop       (w_yumi),
        .o_head      (w_tag),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(w_issue && w_full));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_error <= 1'b0;
        end else if (pow2_v_i && w_empty) begin
            r_error <= ERR_PROTOCOL;
        end
    end

    assign error_o = r_error;

endmodule
